// File: rtl/alu.sv
// Registered WIDTH-bit ALU: eight ops, result plus carry/zero/overflow flags,
// one cycle latency, one op per cycle.
module alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       op,
   input  logic             in_c,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   output logic [WIDTH-1:0] out_s,
   output logic             out_c,
   output logic             zero,
   output logic             overflow
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic             w_v_add;
   logic             w_v_sub;
   logic             w_lt;
   logic [WIDTH-1:0] w_s;
   logic             w_c;
   logic             w_v;

   logic [WIDTH-1:0] r_s;
   logic             r_c;
   logic             r_zero;
   logic             r_v;

   assign w_add = {1'b0, in_x} + {1'b0, in_y}
                + {{WIDTH{1'b0}}, in_c};
   assign w_sub = {1'b0, in_x} + {1'b0, ~in_y}
                + {{WIDTH{1'b0}}, 1'b1};

   assign w_v_add = (in_x[MSB] == in_y[MSB])
                  && (w_add[MSB] != in_x[MSB]);
   assign w_v_sub = (in_x[MSB] != in_y[MSB])
                  && (w_sub[MSB] != in_x[MSB]);

   // Signed less-than from the subtractor sign corrected by overflow
   assign w_lt = w_sub[MSB] ^ w_v_sub;

   always_comb begin
      w_s = '0;
      w_c = 1'b0;
      w_v = 1'b0;
      unique case (op)
         3'b000: begin
            w_s = w_add[MSB:0];
            w_c = w_add[WIDTH];
            w_v = w_v_add;
         end
         3'b001: begin
            w_s = w_sub[MSB:0];
            w_c = w_sub[WIDTH];
            w_v = w_v_sub;
         end
         3'b010: w_s = ~in_x;
         3'b011: w_s = in_x & in_y;
         3'b100: w_s = in_x | in_y;
         3'b101: w_s = in_x ^ in_y;
         3'b110: w_s = {{(WIDTH-1){1'b0}}, w_lt};
         3'b111: w_s = {{(WIDTH-1){1'b0}}, (in_x == in_y)};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s    <= '0;
         r_c    <= 1'b0;
         r_zero <= 1'b0;
         r_v    <= 1'b0;
      end else begin
         r_s    <= w_s;
         r_c    <= w_c;
         r_zero <= (w_s == '0);
         r_v    <= w_v;
      end
   end

   assign out_s    = r_s;
   assign out_c    = r_c;
   assign zero     = r_zero;
   assign overflow = r_v;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vectors from the plan plus random ops
// checked against an integer-arithmetic reference model.
module tb_alu;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk;
   logic         rst_n;
   logic [2:0]   op;
   logic         in_c;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic [W-1:0] out_s;
   logic         out_c;
   logic         zero;
   logic         overflow;

   int n_pass = 0;
   int n_total = 0;

   alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op       (op),
      .in_c     (in_c),
      .in_x     (in_x),
      .in_y     (in_y),
      .out_s    (out_s),
      .out_c    (out_c),
      .zero     (zero),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sgn(input int u);
      return (u >= M / 2) ? u - M : u;
   endfunction

   // Reference: plain integer arithmetic, signed range check for overflow
   function automatic void model(input int o, input int x, input int y,
                                 input int ci, output int s, output int c,
                                 output int v);
      int sum;
      int ssum;
      s = 0; c = 0; v = 0;
      case (o)
         0: begin
            sum  = x + y + ci;
            s    = sum % M;
            c    = (sum >= M) ? 1 : 0;
            ssum = sgn(x) + sgn(y) + ci;
            v    = (ssum > M / 2 - 1 || ssum < -M / 2) ? 1 : 0;
         end
         1: begin
            s    = (x - y + M) % M;
            c    = (x >= y) ? 1 : 0;
            ssum = sgn(x) - sgn(y);
            v    = (ssum > M / 2 - 1 || ssum < -M / 2) ? 1 : 0;
         end
         2: s = (M - 1) - x;
         3: s = x & y;
         4: s = x | y;
         5: s = x ^ y;
         6: s = (sgn(x) < sgn(y)) ? 1 : 0;
         default: s = (x == y) ? 1 : 0;
      endcase
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input int s, input int c,
                            input int z, input int v);
      check({tag, ".s"}, int'(out_s), s);
      check({tag, ".c"}, int'(out_c), c);
      check({tag, ".zero"}, int'(zero), z);
      check({tag, ".v"}, int'(overflow), v);
   endtask

   // Drive one op, clock it, then verify against the model
   task automatic run_op(input string tag, input int o, input int x,
                         input int y, input int ci);
      int s, c, v;
      op   = 3'(o);
      in_x = W'(x);
      in_y = W'(y);
      in_c = 1'(ci);
      model(o, x, y, ci, s, c, v);
      @(posedge clk);
      #1;
      check_all(tag, s, c, (s == 0) ? 1 : 0, v);
   endtask

   // Directed vector with hand-written expectations
   task automatic dir_op(input string tag, input int o, input int x,
                         input int y, input int ci, input int es,
                         input int ec, input int ez, input int ev);
      op   = 3'(o);
      in_x = W'(x);
      in_y = W'(y);
      in_c = 1'(ci);
      @(posedge clk);
      #1;
      check_all(tag, es, ec, ez, ev);
   endtask

   initial begin
      rst_n = 1'b0;
      op    = '0;
      in_c  = 1'b0;
      in_x  = '0;
      in_y  = '0;
      #1;
      check_all("reset0", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("reset_hold", 0, 0, 0, 0);
      rst_n = 1'b1;

      dir_op("add1", 0, 4'b0001, 4'b0001, 0, 4'b0010, 0, 0, 0);
      dir_op("add_v", 0, 4'b0111, 4'b0001, 0, 4'b1000, 0, 0, 1);
      dir_op("add_z", 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0);
      dir_op("add_cz", 0, 4'b0011, 4'b1101, 0, 4'b0000, 1, 1, 0);
      dir_op("add_ci", 0, 4'b0011, 4'b0100, 1, 4'b1000, 0, 0, 1);
      dir_op("sub_v", 1, 4'b1000, 4'b0001, 0, 4'b0111, 1, 0, 1);
      dir_op("sub_z", 1, 4'b0011, 4'b0011, 1, 4'b0000, 1, 1, 0);
      dir_op("sub_b", 1, 4'b0000, 4'b0001, 0, 4'b1111, 0, 0, 0);
      dir_op("not", 2, 4'b1100, 4'b1010, 1, 4'b0011, 0, 0, 0);
      dir_op("and", 3, 4'b1100, 4'b1010, 0, 4'b1000, 0, 0, 0);
      dir_op("or", 4, 4'b1100, 4'b1010, 0, 4'b1110, 0, 0, 0);
      dir_op("xor", 5, 4'b1100, 4'b1010, 0, 4'b0110, 0, 0, 0);
      dir_op("xor_z", 5, 4'b0101, 4'b0101, 0, 4'b0000, 0, 1, 0);
      dir_op("slt1", 6, 4'b1000, 4'b0111, 0, 4'b0001, 0, 0, 0);
      dir_op("slt0", 6, 4'b0111, 4'b1000, 0, 4'b0000, 0, 1, 0);
      dir_op("eq1", 7, 4'b1010, 4'b1010, 0, 4'b0001, 0, 0, 0);
      dir_op("eq0", 7, 4'b1010, 4'b1011, 0, 4'b0000, 0, 1, 0);

      // Mid-cycle asynchronous reset after a 0111/c=1/v=1 result
      dir_op("pre_rst", 1, 4'b1000, 4'b0001, 0, 4'b0111, 1, 0, 1);
      op   = 3'd0;
      in_x = 4'b0111;
      in_y = 4'b0111;
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("rst_low_edge", 0, 0, 0, 0);
      rst_n = 1'b1;
      dir_op("post_rst", 0, 4'b0001, 4'b0001, 0, 4'b0010, 0, 0, 0);

      // Inputs changing between edges must not disturb held outputs
      in_x = 4'b1111;
      #2;
      check("hold.s", int'(out_s), 2);

      // Back-to-back random ops, one per edge
      for (int i = 0; i < 300; i++) begin
         run_op("rand", int'($urandom_range(7, 0)),
                int'($urandom_range(M - 1, 0)),
                int'($urandom_range(M - 1, 0)),
                int'($urandom_range(1, 0)));
      end

      // Exhaustive SUB/SLT/ADD sweep for the signed boundaries
      for (int x = 0; x < M; x++) begin
         for (int y = 0; y < M; y++) begin
            run_op("sweep_sub", 1, x, y, 0);
            run_op("sweep_slt", 6, x, y, 0);
            run_op("sweep_add", 0, x, y, 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
